// File: rtl/ysyx_22040759_axi_burst_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst write master and the crossbar.
// The master modport drives AW/W and B ready; the slave modport is the crossbar side.
interface ysyx_22040759_axi_burst_wr_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int USER_W = 1
);
   logic                  aw_ready;
   logic                  aw_valid;
   logic [ADDR_W-1:0]     aw_addr;
   logic [2:0]            aw_prot;
   logic [ID_W-1:0]       aw_id;
   logic [USER_W-1:0]     aw_user;
   logic [7:0]            aw_len;
   logic [2:0]            aw_size;
   logic [1:0]            aw_burst;
   logic                  aw_lock;
   logic [3:0]            aw_cache;
   logic [3:0]            aw_qos;

   logic                  w_ready;
   logic                  w_valid;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   w_strb;
   logic                  w_last;

   logic                  b_ready;
   logic                  b_valid;
   logic [1:0]            b_resp;
   logic [ID_W-1:0]       b_id;
   logic [USER_W-1:0]     b_user;

   modport master (
      input  aw_ready,
      output aw_valid, aw_addr, aw_prot, aw_id, aw_user, aw_len, aw_size,
             aw_burst, aw_lock, aw_cache, aw_qos,
      input  w_ready,
      output w_valid, w_data, w_strb, w_last,
      output b_ready,
      input  b_valid, b_resp, b_id, b_user
   );

   modport slave (
      output aw_ready,
      input  aw_valid, aw_addr, aw_prot, aw_id, aw_user, aw_len, aw_size,
             aw_burst, aw_lock, aw_cache, aw_qos,
      output w_ready,
      input  w_valid, w_data, w_strb, w_last,
      input  b_ready,
      output b_valid, b_resp, b_id, b_user
   );
endinterface

// File: rtl/ysyx_22040759_axi_burst_wr.sv
// AXI4 INCR burst write master: one request, streamed beats placed on byte lanes, B reported.
// Define YSYX_22040759_AXI_AW_W_OVERLAP_EN to let AW and W handshake in any order.
module ysyx_22040759_axi_burst_wr #(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_USER_WIDTH = 1,
   parameter int MAX_LEN        = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [2:0]                req_size_i,
   input  logic [MAX_LEN-1:0]        req_len_i,
   input  logic                      wd_valid_i,
   output logic                      wd_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0] wd_data_i,
   output logic                      done_o,
   output logic [1:0]                resp_o,
   output logic                      err_o,
   output logic [1:0]                dbg_state_o,
   output logic [MAX_LEN-1:0]        dbg_beat_cnt_o,
   ysyx_22040759_axi_burst_wr_if.master axi
);
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // every valid stays asserted, with its payload stable, until that edge.
   state_e                    state_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [2:0]                size_q;
   logic [MAX_LEN-1:0]        len_q;
   logic [MAX_LEN-1:0]        beat_cnt_q;
   logic [OFF_W-1:0]          off_q;
   logic                      req_ready_q;
   logic                      aw_valid_q;
   logic                      b_ready_q;
   logic                      done_q;
   logic                      err_q;
   logic [1:0]                resp_q;
`ifdef YSYX_22040759_AXI_AW_W_OVERLAP_EN
   logic                      aw_done_q;
   logic                      w_done_q;
`endif

   logic [2:0]                size_c;
   logic [AXI_ADDR_WIDTH-1:0] addr_c;
   logic [OFF_W:0]            step_c;
   logic [STRB_W-1:0]         strb_base_c;
   logic                      w_active_c;
   logic                      w_fire_c;
   logic                      aw_fire_c;
   logic                      last_c;
   logic                      unused_b;

   assign size_c = (req_size_i > MAX_SIZE) ? MAX_SIZE : req_size_i;
   assign addr_c = req_addr_i & ~((AXI_ADDR_WIDTH'(1) << size_c) - AXI_ADDR_WIDTH'(1));
   // Only the lane offset of the running beat address matters; it wraps modulo the bus width.
   assign step_c = (OFF_W+1)'(1) << size_q;

   always_comb begin
      strb_base_c = '0;
      for (int i = 0; i < STRB_W; i++) strb_base_c[i] = (i < (1 << size_q));
   end

`ifdef YSYX_22040759_AXI_AW_W_OVERLAP_EN
   assign w_active_c = (state_q == DATA) && !w_done_q;
`else
   assign w_active_c = (state_q == DATA);
`endif
   assign w_fire_c  = w_active_c && wd_valid_i && axi.w_ready;
   assign aw_fire_c = aw_valid_q && axi.aw_ready;
   assign last_c    = (beat_cnt_q == len_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         off_q       <= '0;
         req_ready_q <= 1'b1;
         aw_valid_q  <= 1'b0;
         b_ready_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         resp_q      <= 2'b00;
`ifdef YSYX_22040759_AXI_AW_W_OVERLAP_EN
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         resp_q <= 2'b00;
         case (state_q)
            IDLE: begin
               if (req_valid_i && req_ready_q) begin
                  addr_q      <= addr_c;
                  size_q      <= size_c;
                  len_q       <= req_len_i;
                  beat_cnt_q  <= '0;
                  off_q       <= addr_c[OFF_W-1:0];
                  req_ready_q <= 1'b0;
                  aw_valid_q  <= 1'b1;
`ifdef YSYX_22040759_AXI_AW_W_OVERLAP_EN
                  aw_done_q   <= 1'b0;
                  w_done_q    <= 1'b0;
                  state_q     <= DATA;
`else
                  state_q     <= ADDR;
`endif
               end
            end
            ADDR: begin
               if (aw_fire_c) begin
                  aw_valid_q <= 1'b0;
                  state_q    <= DATA;
               end
            end
            DATA: begin
               if (w_fire_c) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  off_q      <= off_q + step_c[OFF_W-1:0];
               end
`ifdef YSYX_22040759_AXI_AW_W_OVERLAP_EN
               if (aw_fire_c) begin
                  aw_valid_q <= 1'b0;
                  aw_done_q  <= 1'b1;
               end
               if (w_fire_c && last_c) w_done_q <= 1'b1;
               if ((aw_done_q || aw_fire_c) && (w_done_q || (w_fire_c && last_c))) begin
                  b_ready_q <= 1'b1;
                  state_q   <= RESP;
               end
`else
               if (w_fire_c && last_c) begin
                  b_ready_q <= 1'b1;
                  state_q   <= RESP;
               end
`endif
            end
            RESP: begin
               if (axi.b_valid) begin
                  b_ready_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  done_q      <= 1'b1;
                  resp_q      <= axi.b_resp;
                  err_q       <= (axi.b_resp != 2'b00);
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o    = req_ready_q;
   assign wd_ready_o     = w_active_c && axi.w_ready;
   assign done_o         = done_q;
   assign resp_o         = resp_q;
   assign err_o          = err_q;
   assign dbg_state_o    = state_q;
   assign dbg_beat_cnt_o = beat_cnt_q;

   // AxPROT 000 = unprivileged/secure/data; AxCACHE 0010 = normal non-cacheable non-bufferable.
   assign axi.aw_valid = aw_valid_q;
   assign axi.aw_addr  = addr_q;
   assign axi.aw_prot  = 3'b000;
   assign axi.aw_id    = '0;
   assign axi.aw_user  = '0;
   assign axi.aw_len   = 8'(len_q);
   assign axi.aw_size  = size_q;
   assign axi.aw_burst = 2'b01;
   assign axi.aw_lock  = 1'b0;
   assign axi.aw_cache = 4'b0010;
   assign axi.aw_qos   = 4'b0000;

   assign axi.w_valid  = w_active_c && wd_valid_i;
   assign axi.w_data   = wd_data_i << {off_q, 3'b000};
   assign axi.w_strb   = strb_base_c << off_q;
   assign axi.w_last   = last_c;

   assign axi.b_ready  = b_ready_q;
   assign unused_b     = ^{axi.b_id, axi.b_user};
endmodule

// File: tb/tb_ysyx_22040759_axi_burst_wr.sv
// Directed bench for the AXI burst write master: lane placement, stalls, B errors, reset, clamp.
// Build with YSYX_22040759_AXI_AW_W_OVERLAP_EN defined to run the overlapped-phase scenarios.
module tb_ysyx_22040759_axi_burst_wr;
   localparam int DW = 64;
   localparam int AW = 64;
   localparam int ML = 8;
   localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_RESP = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i = '0;
   logic [2:0]    req_size_i = '0;
   logic [ML-1:0] req_len_i = '0;
   logic          wd_valid_i = 1'b0;
   logic          wd_ready_o;
   logic [DW-1:0] wd_data_i = '0;
   logic          done_o;
   logic [1:0]    resp_o;
   logic          err_o;
   logic [1:0]    dbg_state_o;
   logic [ML-1:0] dbg_beat_cnt_o;

   int total = 0;
   int bad = 0;
   logic [DW-1:0] exp_q[$];

   ysyx_22040759_axi_burst_wr_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(4), .USER_W(1)) axi ();

   ysyx_22040759_axi_burst_wr #(
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(4),
      .AXI_USER_WIDTH(1), .MAX_LEN(ML)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_size_i(req_size_i), .req_len_i(req_len_i),
      .wd_valid_i(wd_valid_i), .wd_ready_o(wd_ready_o), .wd_data_i(wd_data_i),
      .done_o(done_o), .resp_o(resp_o), .err_o(err_o),
      .dbg_state_o(dbg_state_o), .dbg_beat_cnt_o(dbg_beat_cnt_o),
      .axi(axi)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [AW-1:0] a, input logic [2:0] s, input logic [ML-1:0] l);
      req_valid_i = 1'b1;
      req_addr_i  = a;
      req_size_i  = s;
      req_len_i   = l;
   endtask

   initial begin
      logic [7:0] strb_tab [4];
      int         shift_tab [4];
      int         hs, sv, sr;
      logic       v, r;

      axi.aw_ready = 1'b0;
      axi.w_ready  = 1'b1;
      axi.b_valid  = 1'b0;
      axi.b_resp   = 2'b00;
      axi.b_id     = '0;
      axi.b_user   = '0;
      wd_valid_i   = 1'b1;

      // reset state
      tick();
      tick();
      chk("rst_req_ready", req_ready_o, 1'b1);
      chk("rst_aw_valid", axi.aw_valid, 1'b0);
      chk("rst_w_valid", axi.w_valid, 1'b0);
      chk("rst_wd_ready", wd_ready_o, 1'b0);
      chk("rst_b_ready", axi.b_ready, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_resp", resp_o, 2'b00);
      chk("rst_state", dbg_state_o, S_IDLE);
      chk("rst_beat_cnt", dbg_beat_cnt_o, 0);
      rst = 1'b0;
      wd_valid_i = 1'b0;
      tick();

`ifdef YSYX_22040759_AXI_AW_W_OVERLAP_EN
      // AW held off until after the last W beat
      axi.aw_ready = 1'b0; axi.w_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b00;
      wd_valid_i = 1'b1; wd_data_i = 64'h1;
      drive_req(64'h100, 3'd3, 8'd1);
      tick();
      req_valid_i = 1'b0;
      chk("ov_state_data", dbg_state_o, S_DATA);
      chk("ov_aw_valid", axi.aw_valid, 1'b1);
      chk("ov_w_valid", axi.w_valid, 1'b1);
      chk("ov_w_data0", axi.w_data, 64'h1);
      tick();
      wd_data_i = 64'h2;
      #1;
      chk("ov_w_last", axi.w_last, 1'b1);
      tick();
      chk("ov_w_gated", axi.w_valid, 1'b0);
      chk("ov_wait_aw", dbg_state_o, S_DATA);
      tick();
      chk("ov_still_wait", dbg_state_o, S_DATA);
      chk("ov_no_done", done_o, 1'b0);
      axi.aw_ready = 1'b1;
      tick();
      chk("ov_resp", dbg_state_o, S_RESP);
      tick();
      chk("ov_done", done_o, 1'b1);
      // AW and W in the same cycle
      wd_data_i = 64'hAB;
      drive_req(64'h8000_0003, 3'd0, 8'd0);
      tick();
      req_valid_i = 1'b0;
      chk("ov2_both_valid", {axi.aw_valid, axi.w_valid}, 2'b11);
      chk("ov2_data", axi.w_data, 64'hAB00_0000);
      tick();
      chk("ov2_resp", dbg_state_o, S_RESP);
      tick();
      chk("ov2_done", done_o, 1'b1);
`else
      // single beat, minimum latency, byte lane 3
      axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b00;
      wd_valid_i = 1'b1; wd_data_i = 64'hAB;
      drive_req(64'h8000_0003, 3'd0, 8'd0);
      tick();
      req_valid_i = 1'b0;
      chk("t1_state_addr", dbg_state_o, S_ADDR);
      chk("t1_req_ready", req_ready_o, 1'b0);
      chk("t1_aw_valid", axi.aw_valid, 1'b1);
      chk("t1_aw_addr", axi.aw_addr, 64'h8000_0003);
      chk("t1_aw_size", axi.aw_size, 3'd0);
      chk("t1_aw_len", axi.aw_len, 8'd0);
      chk("t1_aw_static", {axi.aw_burst, axi.aw_cache, axi.aw_prot, axi.aw_lock, axi.aw_qos, axi.aw_id},
          {2'b01, 4'b0010, 3'b000, 1'b0, 4'h0, 4'h0});
      chk("t1_w_idle", axi.w_valid, 1'b0);
      tick();
      chk("t1_state_data", dbg_state_o, S_DATA);
      chk("t1_w_valid", axi.w_valid, 1'b1);
      chk("t1_w_data", axi.w_data, 64'hAB00_0000);
      chk("t1_w_strb", axi.w_strb, 8'h08);
      chk("t1_w_last", axi.w_last, 1'b1);
      chk("t1_wd_ready", wd_ready_o, 1'b1);
      tick();
      chk("t1_state_resp", dbg_state_o, S_RESP);
      chk("t1_b_ready", axi.b_ready, 1'b1);
      chk("t1_w_off", axi.w_valid, 1'b0);
      tick();
      chk("t1_done", done_o, 1'b1);
      chk("t1_err", err_o, 1'b0);
      chk("t1_req_ready_done", req_ready_o, 1'b1);
      tick();
      chk("t1_done_pulse", done_o, 1'b0);

      // 4-beat word burst at a half-bus offset
      strb_tab  = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
      shift_tab = '{32, 0, 32, 0};
      wd_data_i = 64'd1;
      drive_req(64'h8000_0004, 3'd2, 8'd3);
      tick();
      req_valid_i = 1'b0;
      chk("t2_aw_addr", axi.aw_addr, 64'h8000_0004);
      chk("t2_aw_size_len", {axi.aw_size, axi.aw_len}, {3'd2, 8'd3});
      tick();
      for (int i = 0; i < 4; i++) begin
         wd_data_i = 64'(i + 1);
         #1;
         chk($sformatf("t2_cnt%0d", i), dbg_beat_cnt_o, i);
         chk($sformatf("t2_strb%0d", i), axi.w_strb, strb_tab[i]);
         chk($sformatf("t2_data%0d", i), axi.w_data, 64'(i + 1) << shift_tab[i]);
         chk($sformatf("t2_last%0d", i), axi.w_last, (i == 3));
         tick();
      end
      chk("t2_state_resp", dbg_state_o, S_RESP);
      tick();
      chk("t2_done", done_o, 1'b1);

      // 8 doubleword beats with source and sink stalls
      axi.aw_ready = 1'b0; axi.b_valid = 1'b0; wd_valid_i = 1'b0;
      drive_req(64'h1000, 3'd3, 8'd7);
      tick();
      req_valid_i = 1'b0;
      tick();
      chk("t3_aw_hold", axi.aw_valid, 1'b1);
      chk("t3_aw_addr_stable", axi.aw_addr, 64'h1000);
      chk("t3_state_addr", dbg_state_o, S_ADDR);
      axi.aw_ready = 1'b1;
      tick();
      axi.aw_ready = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(64'hC0DE_0000_0000_0000 | 64'(i * 17));
      hs = 0; sv = 0; sr = 0;
      for (int c = 0; c < 40 && hs < 8; c++) begin
         v = !(hs == 2 && sv < 3);
         r = !(hs == 5 && sr < 1);
         wd_valid_i = v;
         axi.w_ready = r;
         wd_data_i = exp_q[0];
         #1;
         chk("t3_cnt", dbg_beat_cnt_o, hs);
         if (v && r) begin
            chk("t3_w_valid", axi.w_valid, 1'b1);
            chk("t3_w_data", axi.w_data, exp_q[0]);
            chk("t3_w_strb", axi.w_strb, 8'hFF);
            chk("t3_w_last", axi.w_last, (hs == 7));
            void'(exp_q.pop_front());
            hs++;
         end else begin
            chk("t3_stall_valid", axi.w_valid, v);
            chk("t3_stall_ready", wd_ready_o, r);
            if (!v) sv++;
            else sr++;
         end
         tick();
      end
      wd_valid_i = 1'b0;
      axi.w_ready = 1'b1;
      chk("t3_handshakes", hs, 8);
      chk("t3_stalls", {sv[3:0], sr[3:0]}, 8'h31);
      chk("t3_state_resp", dbg_state_o, S_RESP);

      // SLVERR response, pulse for one cycle
      tick();
      chk("t4_wait_b", {dbg_state_o, axi.b_ready, done_o}, {S_RESP, 1'b1, 1'b0});
      axi.b_valid = 1'b1; axi.b_resp = 2'b10;
      tick();
      axi.b_valid = 1'b0; axi.b_resp = 2'b00;
      chk("t4_done", done_o, 1'b1);
      chk("t4_resp", resp_o, 2'b10);
      chk("t4_err", err_o, 1'b1);
      tick();
      chk("t4_pulse", {done_o, resp_o, err_o}, 4'b0000);

      // reset in DATA after two of four beats
      axi.aw_ready = 1'b1; wd_valid_i = 1'b1; wd_data_i = 64'h55;
      drive_req(64'h2000, 3'd3, 8'd3);
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();
      tick();
      chk("t5_cnt2", {dbg_state_o, dbg_beat_cnt_o}, {S_DATA, 8'd2});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_state", dbg_state_o, S_IDLE);
      chk("t5_valids", {axi.aw_valid, axi.w_valid, axi.b_ready, wd_ready_o}, 4'b0000);
      chk("t5_req_ready", req_ready_o, 1'b1);
      chk("t5_cnt0", dbg_beat_cnt_o, 0);

      // fresh halfword request at lane 6, then a back-to-back clamped request
      axi.b_valid = 1'b1; wd_data_i = 64'h1234;
      drive_req(64'h16, 3'd1, 8'd0);
      tick();
      req_valid_i = 1'b0;
      chk("t6_aw", {axi.aw_valid, axi.aw_size}, {1'b1, 3'd1});
      chk("t6_aw_addr", axi.aw_addr, 64'h16);
      tick();
      chk("t6_data", axi.w_data, 64'h1234_0000_0000_0000);
      chk("t6_strb", axi.w_strb, 8'hC0);
      tick();
      tick();
      chk("t6_done", {done_o, req_ready_o}, 2'b11);
      wd_data_i = 64'h0102_0304_0506_0708;
      drive_req(64'h800F, 3'd7, 8'd0);
      tick();
      req_valid_i = 1'b0;
      chk("t7_b2b_accept", {dbg_state_o, done_o}, {S_ADDR, 1'b0});
      chk("t7_clamp_size", axi.aw_size, 3'd3);
      chk("t7_aligned_addr", axi.aw_addr, 64'h8008);
      tick();
      chk("t7_strb", axi.w_strb, 8'hFF);
      chk("t7_data", axi.w_data, 64'h0102_0304_0506_0708);
      tick();
      tick();
      chk("t7_done", {done_o, err_o}, 2'b10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
